// File: rtl/liang_pkg.sv
// liang_pkg: shared core types for the front end.
//   XLEN        - datapath / PC width
//   pc_t        - program counter word
//   inst_t      - 32-bit instruction word
//   INST_BYTES  - byte stride between sequential instructions
//   ifu_state_e - fetch-stage FSM states
//   fetch_pkt_t - {pc, inst} pair handed from fetch to decode
package liang_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [31:0]     inst_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_e;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fetch_pkt_t;

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding the single-cycle decoder.
// Owns the architectural PC, keeps at most one instruction-memory request
// outstanding, and presents each returned word with its PC over a
// valid/ready handshake. Redirects retarget the PC and mark any fetch in
// flight as stale so its response is discarded.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   imem_req_valid_o/ready_i     fetch request handshake
//   imem_req_addr_o              fetch address (current PC)
//   imem_rsp_valid_i/data_i      returned instruction word
//   redirect_valid_i/pc_i        control-flow redirect from execute
//   out_valid_o/ready_i          {pc, inst} handshake to decoder
//   out_pc_o, out_inst_o         presented pair
// All outputs come from registers; no input reaches an output combinationally.
module ifu_fetch #(
    parameter int unsigned     XLEN     = liang_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [31:0]     out_inst_o
);
    import liang_pkg::*;

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            req_valid_q;
    fetch_pkt_t      pkt_q, pkt_d;
    logic [XLEN-1:0] target;

    // Low two bits of the redirect target are ignored (word-aligned fetch).
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];
    assign target = {redirect_pc_i[XLEN-1:2], 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            pkt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            // Registered copy of "next state is S_REQ": keeps the request
            // low for the cycle following reset and off any input path.
            req_valid_q <= (state_d == S_REQ);
            pkt_q       <= pkt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        pkt_d   = pkt_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid_i) begin
                    pc_d = target;
                end
                if (req_valid_q && imem_req_ready_i) begin
                    state_d = S_WAIT;
                    // Accepted request was for the old PC; its word is stale.
                    drop_d  = redirect_valid_i;
                end
            end
            S_WAIT: begin
                if (redirect_valid_i) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
                if (imem_rsp_valid_i) begin
                    if (drop_q || redirect_valid_i) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        pkt_d.pc   = pc_q;
                        pkt_d.inst = imem_rsp_data_i;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A same-cycle handshake is delivered; the redirect still wins
                // for the next PC.
                if (redirect_valid_i) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (out_ready_i) begin
                    pc_d    = pc_q + XLEN'(INST_BYTES);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = pc_q;
    assign out_valid_o      = (state_q == S_HOLD);
    assign out_pc_o         = pkt_q.pc;
    assign out_inst_o       = pkt_q.inst;

endmodule
